// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared receiver state encoding and counter-width helper.
//            Optional build macro: UART_RX_PARITY_EN (adds the PARITY state).
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Brief    : Single-frame UART receiver: synchronizer, frame FSM, bit sampler.
//            Optional build macro: UART_RX_PARITY_EN (parity bit after data).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int STOP_BITS        = 1,
  parameter int PARITY_ODD       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_i,
  output logic [BITS_PER_WORD-1:0] word_o,
  output logic                     word_valid_o,
  output logic                     frame_err_o,
  output logic                     parity_err_o,
  output logic                     idle_o
);

  localparam int              c_cnt_w    = cnt_width(CLOCKS_PER_PULSE + 1);
  localparam int              c_bit_w    = cnt_width(BITS_PER_WORD);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLOCKS_PER_PULSE / 2);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(CLOCKS_PER_PULSE);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(BITS_PER_WORD - 1);
  localparam logic               c_stop_last = 1'(STOP_BITS - 1);

  logic                     rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e                state_q;
  logic [c_cnt_w-1:0]       cnt_q;
  logic [c_bit_w-1:0]       bit_idx_q;
  logic                     stop_idx_q;
  logic [BITS_PER_WORD-1:0] shift_q, word_q;
  logic                     valid_q, ferr_q;
  logic                     w_tick;

  // Counter runs down from its load value; a sample is taken when it hits 1.
  assign w_tick = (cnt_q == c_cnt_one);

`ifdef UART_RX_PARITY_EN
  localparam logic c_par_odd = PARITY_ODD[0];
  logic par_bad_q, perr_q;
  logic w_par_bad;
  assign w_par_bad    = (^shift_q) ^ rx_sync_q ^ c_par_odd;
  assign parity_err_o = perr_q;
`else
  if (PARITY_ODD != 0) begin : g_parity_sense_unused
  end
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      if (state_q != ST_IDLE) begin
        cnt_q <= w_tick ? c_cnt_full : cnt_q - c_cnt_one;
      end
      case (state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= ST_START;
            cnt_q   <= c_cnt_half;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (rx_sync_q) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            shift_q <= {rx_sync_q, shift_q[BITS_PER_WORD-1:1]};
            if (bit_idx_q == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
              state_q    <= ST_PARITY;
`else
              state_q    <= ST_STOP;
`endif
              stop_idx_q <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + c_bit_one;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            par_bad_q  <= w_par_bad;
            perr_q     <= w_par_bad;
            state_q    <= ST_STOP;
            stop_idx_q <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (!rx_sync_q) begin
              ferr_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else if (stop_idx_q == c_stop_last) begin
              state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (!par_bad_q) begin
                word_q  <= shift_q;
                valid_q <= 1'b1;
              end
`else
              word_q  <= shift_q;
              valid_q <= 1'b1;
`endif
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign idle_o       = (state_q == ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/uart_rx_packer.sv
// ============================================================================
// Module   : uart_rx_packer
// Brief    : Packs N_WORDS received UART frames into one valid/ready beat.
//            Optional build macro: UART_RX_PARITY_EN (parity check per frame).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int N_WORDS          = 4,
  parameter int STOP_BITS        = 1,
  parameter int PARITY_ODD       = 0,
  parameter int TIMEOUT_PULSES   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx,
  input  logic                             m_ready,
  output logic                             m_valid,
  output logic [N_WORDS*BITS_PER_WORD-1:0] m_data,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overflow,
  output logic                             timeout
);

  localparam int                c_beat_w = N_WORDS * BITS_PER_WORD;
  localparam int                c_idx_w  = cnt_width(N_WORDS);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_WORDS - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  logic [BITS_PER_WORD-1:0] w_word;
  logic                     w_word_valid, w_idle, w_timeout_hit;

  logic [c_idx_w-1:0]  idx_q, idx_d;
  logic [c_beat_w-1:0] asm_q, asm_d, mdata_q, mdata_d;
  logic                mvalid_q, mvalid_d, ovf_q, ovf_d, to_q, to_d;

  uart_rx_frame #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD),
    .STOP_BITS       (STOP_BITS),
    .PARITY_ODD      (PARITY_ODD)
  ) u_frame (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .word_o      (w_word),
    .word_valid_o(w_word_valid),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .idle_o      (w_idle)
  );

  always_comb begin
    idx_d    = idx_q;
    asm_d    = asm_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    ovf_d    = 1'b0;
    to_d     = 1'b0;
    if (mvalid_q && m_ready) begin
      mvalid_d = 1'b0;
    end
    if (w_word_valid) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (idx_q == c_idx_w'(i)) begin
          asm_d[i*BITS_PER_WORD +: BITS_PER_WORD] = w_word;
        end
      end
      if (idx_q == c_idx_last) begin
        idx_d = '0;
        // A held, unaccepted beat wins over the newly completed one.
        if (mvalid_q && !m_ready) begin
          ovf_d = 1'b1;
        end else begin
          mdata_d  = asm_d;
          mvalid_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + c_idx_one;
      end
    end else if (w_timeout_hit) begin
      idx_d = '0;
      to_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      asm_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
    end
  end

  if (TIMEOUT_PULSES > 0) begin : g_timeout
    localparam int               c_limit = TIMEOUT_PULSES * CLOCKS_PER_PULSE;
    localparam int               c_tw    = cnt_width(c_limit);
    localparam logic [c_tw-1:0]  c_t_one = c_tw'(1);
    localparam logic [c_tw-1:0]  c_t_end = c_tw'(c_limit - 1);
    logic [c_tw-1:0] idle_cnt_q;
    logic            w_armed;

    assign w_armed       = w_idle && (idx_q != '0) && !w_word_valid;
    assign w_timeout_hit = w_armed && (idle_cnt_q == c_t_end);

    always_ff @(posedge clk) begin
      if (rst || !w_armed || w_timeout_hit) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + c_t_one;
      end
    end
  end else begin : g_no_timeout
    assign w_timeout_hit = 1'b0;
  end

  assign m_valid  = mvalid_q;
  assign m_data   = mdata_q;
  assign overflow = ovf_q;
  assign timeout  = to_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_packer.sv
// ============================================================================
// Module   : tb_uart_rx_packer
// Brief    : Self-checking bench for uart_rx_packer (default parameters).
//            Optional build macro: UART_RX_PARITY_EN (adds parity case).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_packer;

  localparam int CPP  = 4;
  localparam int BPW  = 8;
  localparam int NW   = 4;
  localparam int SB   = 1;
  localparam int PODD = 0;
  localparam int TP   = 32;

  logic              clk = 1'b0;
  logic              rst, rx, m_ready;
  logic              m_valid, frame_err, parity_err, overflow, timeout;
  logic [NW*BPW-1:0] m_data;

  always #5 clk = ~clk;

  uart_rx_packer #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW),
    .N_WORDS         (NW),
    .STOP_BITS       (SB),
    .PARITY_ODD      (PODD),
    .TIMEOUT_PULSES  (TP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ferr_cnt = 0, perr_cnt = 0, ovf_cnt = 0, to_cnt = 0, valid_cycles = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [0:3][7:0] f;
    logic [31:0]     exp;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on each accepted beat.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (overflow)   ovf_cnt++;
        if (timeout)    to_cnt++;
        if (m_valid)    valid_cycles++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", m_data, 32'hxxxx_xxxx);
          end else begin
            check("beat_data", m_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    rx = 1'b0;
    idle(CPP);
    for (int i = 0; i < BPW; i++) begin
      rx = d[i];
      idle(CPP);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ PODD[0] ^ par_flip;
    idle(CPP);
`else
    if (par_flip) rx = 1'b1;
`endif
    for (int s = 0; s < SB; s++) begin
      rx = stop_v;
      idle(CPP);
    end
    rx = 1'b1;
    idle(2);
  endtask

  task automatic send_beat(input logic [31:0] words);
    for (int i = 0; i < NW; i++) send_frame(words[i*8 +: 8], 1'b1, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{f: {8'h11, 8'h22, 8'h33, 8'h44}, exp: 32'h4433_2211};
    vecs[1] = '{f: {8'hA5, 8'h5A, 8'hFF, 8'h00}, exp: 32'h00FF_5AA5};
    vecs[2] = '{f: {8'h01, 8'h80, 8'h7E, 8'hC3}, exp: 32'hC37E_8001};

    rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
    idle(4);
    check("rst_m_valid",    m_valid,    0);
    check("rst_m_data",     m_data,     0);
    check("rst_frame_err",  frame_err,  0);
    check("rst_parity_err", parity_err, 0);
    check("rst_overflow",   overflow,   0);
    check("rst_timeout",    timeout,    0);
    rst = 1'b0;
    idle(4);

    for (int v = 0; v < 3; v++) begin
      valid_cycles = 0;
      exp_q.push_back(vecs[v].exp);
      for (int i = 0; i < NW; i++) send_frame(vecs[v].f[i], 1'b1, 1'b0);
      wait_drain("table");
      idle(3);
      check("valid_one_cycle", valid_cycles, 1);
    end

    // Backpressure: second beat overflows, first beat held then delivered.
    m_ready = 1'b0;
    ovf_cnt = 0;
    exp_q.push_back(32'hB3B2_B1B0);
    send_beat(32'hB3B2_B1B0);
    send_beat(32'hC3C2_C1C0);
    idle(3);
    check("overflow_once", ovf_cnt, 1);
    check("held_valid", m_valid, 1);
    check("held_data", m_data, 32'hB3B2_B1B0);
    m_ready = 1'b1;
    wait_drain("overflow");
    idle(2);
    check("valid_fall", m_valid, 0);

    ferr_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(4);
    check("frame_err_pulse", ferr_cnt, 1);
    exp_q.push_back(32'h4030_2010);
    send_beat(32'h4030_2010);
    wait_drain("after_ferr");

    to_cnt = 0;
    send_frame(8'hEE, 1'b1, 1'b0);
    send_frame(8'hDD, 1'b1, 1'b0);
    idle(TP * CPP + 10);
    check("timeout_pulse", to_cnt, 1);
    check("timeout_no_beat", m_valid, 0);
    exp_q.push_back(32'h0403_0201);
    send_beat(32'h0403_0201);
    wait_drain("after_timeout");

    ferr_cnt = 0;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(20);
    check("glitch_no_err", ferr_cnt, 0);
    exp_q.push_back(32'h8877_6655);
    send_beat(32'h8877_6655);
    wait_drain("after_glitch");

    // Reset in the middle of a frame, with one word already packed.
    send_frame(8'h99, 1'b1, 1'b0);
    rx = 1'b0; idle(CPP);
    rx = 1'b1; idle(CPP);
    rx = 1'b0; idle(CPP);
    rst = 1'b1; rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    check("mid_rst_valid", m_valid, 0);
    exp_q.push_back(32'hDDCC_BBAA);
    send_beat(32'hDDCC_BBAA);
    wait_drain("after_rst");

`ifdef UART_RX_PARITY_EN
    perr_cnt = 0;
    send_frame(8'h03, 1'b1, 1'b1);
    idle(4);
    check("parity_err_pulse", perr_cnt, 1);
    exp_q.push_back(32'h0F0E_0D0C);
    send_beat(32'h0F0E_0D0C);
    wait_drain("after_parity");
`else
    check("parity_err_tied", perr_cnt, 0);
`endif

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
